alu_mult_seq: RTL and testbench

ALU_MULT_SEQ -- requirements
Module: alu_mult_seq

---
 rtl/alu_mult_seq.sv | 126 ++++++++++++
 tb/tb_alu_mult_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_seq.sv
// Sequential shift-add multiplier: low 32 bits of req_a*req_b, computed with
// one ALU addition per RUN cycle on an external combinational ALU.
package alu_mult_seq_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } aluop_t;
endpackage

module alu_mult_seq
  import alu_mult_seq_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   req_valid,
  output logic   req_ready,
  input  word_t  req_a,
  input  word_t  req_b,
  output logic   resp_valid,
  input  logic   resp_ready,
  output word_t  resp_product,
  output logic   resp_zero,
  output aluop_t ALUOP,
  output word_t  portA,
  output word_t  portB,
  input  word_t  portOut,
  input  logic   zero,
  input  logic   neg,
  input  logic   overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  word_t      acc_q, acc_d;
  word_t      mcand_q, mcand_d;
  word_t      mplier_q, mplier_d;
  logic [5:0] iter_q, iter_d;

  // ALU flags are part of the ALU interface but carry no information we need.
  logic unused_flags;
  assign unused_flags = zero ^ neg ^ overflow;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      iter_q   <= iter_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    iter_d     = iter_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ALUOP      = ALU_ADD;
    portA      = '0;
    portB      = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mcand_d  = req_a;
          mplier_d = req_b;
          acc_d    = '0;
          iter_d   = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        portA = acc_q;
        portB = mcand_q;
        if (mplier_q[0]) begin
          acc_d = portOut;
        end
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        iter_d   = iter_q + 6'd1;
        // Early exit once no set multiplier bits remain above the current one.
        if ((iter_q == 6'd31) ||
            ((EARLY_EXIT != 0) && (mplier_q[31:1] == 31'd0))) begin
          state_d = DONE;
        end
      end

      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign resp_product = acc_q;
  assign resp_zero    = (acc_q == 32'd0);

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed self-checking bench for alu_mult_seq; instance 1 uses EARLY_EXIT=1,
// instance 0 uses EARLY_EXIT=0, each wired to its own behavioural adder ALU.
module tb_alu_mult_seq;
  import alu_mult_seq_pkg::*;

  logic   CLK;
  logic   RST;
  logic   req_valid    [2];
  logic   req_ready    [2];
  word_t  req_a        [2];
  word_t  req_b        [2];
  logic   resp_valid   [2];
  logic   resp_ready   [2];
  word_t  resp_product [2];
  logic   resp_zero    [2];
  aluop_t aluop        [2];
  word_t  port_a       [2];
  word_t  port_b       [2];
  word_t  port_out     [2];

  int checks = 0;
  int errors = 0;
  word_t pa_log[$];
  word_t pb_log[$];

  // Behavioural ALU: only ADD is ever requested by the multiplier.
  assign port_out[0] = port_a[0] + port_b[0];
  assign port_out[1] = port_a[1] + port_b[1];

  alu_mult_seq #(.EARLY_EXIT(0)) dut_full (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_product(resp_product[0]), .resp_zero(resp_zero[0]),
    .ALUOP(aluop[0]), .portA(port_a[0]), .portB(port_b[0]),
    .portOut(port_out[0]), .zero(1'b0), .neg(1'b0), .overflow(1'b0)
  );

  alu_mult_seq #(.EARLY_EXIT(1)) dut_early (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_product(resp_product[1]), .resp_zero(resp_zero[1]),
    .ALUOP(aluop[1]), .portA(port_a[1]), .portB(port_b[1]),
    .portOut(port_out[1]), .zero(1'b0), .neg(1'b0), .overflow(1'b0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents one request, then counts RUN cycles until resp_valid (bounded).
  task automatic run_op(input int sel, input word_t a, input word_t b, output int cycles);
    req_a[sel] = a;
    req_b[sel] = b;
    req_valid[sel] = 1'b1;
    tick();
    req_valid[sel] = 1'b0;
    pa_log.delete();
    pb_log.delete();
    cycles = 0;
    while (resp_valid[sel] !== 1'b1 && cycles < 40) begin
      pa_log.push_back(port_a[sel]);
      pb_log.push_back(port_b[sel]);
      tick();
      cycles++;
    end
  endtask

  task automatic finish_op(input int sel);
    resp_ready[sel] = 1'b1;
    tick();
    resp_ready[sel] = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (req_ready[s] !== 1'b1 || resp_valid[s] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_handshake[%0d]: got ready=%b valid=%b, expected ready=1 valid=0",
                 s, req_ready[s], resp_valid[s]);
      end
      checks++;
      if (resp_product[s] !== 32'd0 || resp_zero[s] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_resp[%0d]: got product=%h zero=%b, expected 00000000/1",
                 s, resp_product[s], resp_zero[s]);
      end
      checks++;
      if (aluop[s] !== ALU_ADD || port_a[s] !== 32'd0 || port_b[s] !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_alu[%0d]: got op=%0d A=%h B=%h, expected op=0 A=0 B=0",
                 s, aluop[s], port_a[s], port_b[s]);
      end
    end
    RST = 1'b0;
    tick();
    checks++;
    if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got ready=%b valid=%b, expected 1/0",
               req_ready[1], resp_valid[1]);
    end
  endtask

  task automatic test_early_exit_basic();
    int cyc;
    run_op(1, 32'd3, 32'd5, cyc);
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("[TB] FAIL basic_cycles: got %0d, expected 3", cyc);
    end
    checks++;
    if (pa_log.size() != 3 || pa_log[0] !== 32'd0 || pb_log[0] !== 32'd3 ||
        pa_log[1] !== 32'd3 || pb_log[1] !== 32'd6 ||
        pa_log[2] !== 32'd3 || pb_log[2] !== 32'd12) begin
      errors++;
      $display("[TB] FAIL basic_operands: got %0d cycles, first A=%h B=%h, expected (0,3),(3,6),(3,12)",
               pa_log.size(), pa_log.size() > 0 ? pa_log[0] : 32'hx, pb_log.size() > 0 ? pb_log[0] : 32'hx);
    end
    checks++;
    if (resp_product[1] !== 32'd15 || resp_zero[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result: got product=%h zero=%b ready=%b, expected 0000000f/0/0",
               resp_product[1], resp_zero[1], req_ready[1]);
    end
    finish_op(1);
  endtask

  task automatic test_zero_multiplier();
    int cyc;
    run_op(1, 32'h1234, 32'd0, cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("[TB] FAIL zero_cycles: got %0d, expected 1", cyc);
    end
    checks++;
    if (resp_product[1] !== 32'd0 || resp_zero[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_result: got product=%h zero=%b, expected 00000000/1",
               resp_product[1], resp_zero[1]);
    end
    finish_op(1);
  endtask

  task automatic test_full_iterations();
    int cyc;
    word_t a_vec  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD};
    word_t b_vec  [4] = '{32'hFFFFFFFF, 32'd7,        32'hFFFFFFFF, 32'd7};
    word_t p_vec  [4] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFEB};
    int    c_vec  [4] = '{32, 32, 32, 3};
    int    s_vec  [4] = '{0, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      run_op(s_vec[i], a_vec[i], b_vec[i], cyc);
      checks++;
      if (cyc !== c_vec[i]) begin
        errors++;
        $display("[TB] FAIL full_cycles[%0d]: got %0d, expected %0d", i, cyc, c_vec[i]);
      end
      checks++;
      if (resp_product[s_vec[i]] !== p_vec[i] || resp_zero[s_vec[i]] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL full_result[%0d]: got product=%h zero=%b, expected %h/0",
                 i, resp_product[s_vec[i]], resp_zero[s_vec[i]], p_vec[i]);
      end
      finish_op(s_vec[i]);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad = 0;
    run_op(1, 32'd3, 32'd5, cyc);
    req_a[1] = 32'd9;
    req_b[1] = 32'd9;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid[1] !== 1'b1 || resp_product[1] !== 32'd15 || req_ready[1] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL backpressure_hold: got %0d unstable cycles, expected 0", bad);
    end
    finish_op(1);
    req_valid[1] = 1'b0;
    checks++;
    if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_release: got ready=%b valid=%b, expected 1/0",
               req_ready[1], resp_valid[1]);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int stray = 0;
    req_a[1] = 32'd7;
    req_b[1] = 32'h80000000;
    req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 || resp_product[1] !== 32'd0 ||
        port_a[1] !== 32'd0 || port_b[1] !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: got ready=%b valid=%b product=%h A=%h B=%h, expected 1/0/0/0/0",
               req_ready[1], resp_valid[1], resp_product[1], port_a[1], port_b[1]);
    end
    for (int i = 0; i < 35; i++) begin
      tick();
      if (resp_valid[1] !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL midrun_discard: got %0d response cycles, expected 0", stray);
    end
    run_op(1, 32'd6, 32'd7, cyc);
    checks++;
    if (resp_product[1] !== 32'd42 || cyc !== 3) begin
      errors++;
      $display("[TB] FAIL midrun_next: got product=%0d cycles=%0d, expected 42/3",
               resp_product[1], cyc);
    end
    finish_op(1);
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int early = 0;
    req_a[1] = 32'd3;
    req_b[1] = 32'd5;
    req_valid[1] = 1'b1;
    tick();
    req_a[1] = 32'd6;
    req_b[1] = 32'd7;
    while (resp_valid[1] !== 1'b1 && cyc < 40) begin
      if (req_ready[1] !== 1'b0) early++;
      tick();
      cyc++;
    end
    checks++;
    if (resp_product[1] !== 32'd15 || early != 0 || cyc !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_first: got product=%0d ready_in_run=%0d cycles=%0d, expected 15/0/3",
               resp_product[1], early, cyc);
    end
    resp_ready[1] = 1'b1;
    tick();
    resp_ready[1] = 1'b0;
    checks++;
    if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got ready=%b valid=%b, expected 1/0", req_ready[1], resp_valid[1]);
    end
    tick();
    req_valid[1] = 1'b0;
    checks++;
    if (req_ready[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second_accept: got ready=%b, expected 0", req_ready[1]);
    end
    cyc = 0;
    while (resp_valid[1] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++;
    if (resp_product[1] !== 32'd42 || cyc !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_second: got product=%0d cycles=%0d, expected 42/3", resp_product[1], cyc);
    end
    finish_op(1);
  endtask

  initial begin
    RST = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s]  = 1'b0;
      req_a[s]      = '0;
      req_b[s]      = '0;
      resp_ready[s] = 1'b0;
    end
    test_reset();
    test_early_exit_basic();
    test_zero_multiplier();
    test_full_iterations();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
